// File: rtl/fwd_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwd_hazard_ctrl_pkg: shared types for the EX forwarding/hazard controller |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fwd_hazard_ctrl_pkg;

    // Widest register specifier the tracking entries can hold.
    localparam int c_MAX_REG_W = 8;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_ZERO = 2'b11
    } lc3b_fwd_sel;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'b00,
        HZ_LU    = 2'b01,
        HZ_MWAIT = 2'b10
    } lc3b_hz_state;

    typedef struct packed {
        logic                   valid;
        logic [c_MAX_REG_W-1:0] dest;
        logic                   we;
        logic                   is_load;
    } lc3b_hz_entry;

    function automatic logic hz_match(input lc3b_hz_entry e,
                                      input logic [c_MAX_REG_W-1:0] src);
        return e.valid && e.we && (e.dest == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwd_hazard_ctrl_if: ID-stage operand info in, EX selects and stalls out    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fwd_hazard_ctrl_if #(
    parameter int REG_W = 3
);
    logic             id_valid;
    logic [REG_W-1:0] id_sr1;
    logic [REG_W-1:0] id_sr2;
    logic             id_uses_sr1;
    logic             id_uses_sr2;
    logic             id_uses_srstore;
    logic [REG_W-1:0] id_dest;
    logic             id_we;
    logic             id_is_load;
    logic             flush;
    logic             mem_req;
    logic             mem_resp;
    logic [1:0]       opAmux_sel;
    logic [1:0]       opBmux_sel;
    logic [1:0]       opSrmux_sel;
    logic             stall_if_id;
    logic             bubble_ex;
    logic             freeze;

    modport master (
        output id_valid, id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
               id_uses_srstore, id_dest, id_we, id_is_load,
               flush, mem_req, mem_resp,
        input  opAmux_sel, opBmux_sel, opSrmux_sel,
               stall_if_id, bubble_ex, freeze
    );

    modport slave (
        input  id_valid, id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
               id_uses_srstore, id_dest, id_we, id_is_load,
               flush, mem_req, mem_resp,
        output opAmux_sel, opBmux_sel, opSrmux_sel,
               stall_if_id, bubble_ex, freeze
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_compare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwd_compare: resolves one ID source against the EX and MEM producers       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fwd_compare
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [c_MAX_REG_W-1:0] src,
    input  logic                   use_src,
    input  lc3b_hz_entry           ex_entry,
    input  lc3b_hz_entry           mem_entry,
    output lc3b_fwd_sel            sel,
    output logic                   lu_hit
);
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_unused;

    assign w_ex_hit  = use_src && hz_match(ex_entry, src);
    assign w_mem_hit = use_src && hz_match(mem_entry, src);
    assign lu_hit    = w_ex_hit && ex_entry.is_load;
    assign w_unused  = mem_entry.is_load;

    // The instruction in EX is the youngest producer, so it wins over MEM.
    always_comb begin
        sel = FWD_RF;
        if (w_ex_hit)
            sel = FWD_MEM;
        else if (w_mem_hit)
            sel = FWD_WB;
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwd_hazard_ctrl: EX forwarding selects plus load-use / memory-wait stalls  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_W    = 3,
    parameter int LU_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_ctrl_if.slave  bus
);
    localparam logic [1:0] c_LU_INIT = 2'(LU_STALL - 1);

    lc3b_hz_state r_state;
    lc3b_hz_state r_resume;
    logic [1:0]   r_cnt;
    logic         r_stall;
    logic         r_bubble;
    logic         r_freeze;

    lc3b_hz_entry r_ex;
    lc3b_hz_entry r_mem;
    lc3b_hz_entry r_wb;
    lc3b_fwd_sel  r_opa;
    lc3b_fwd_sel  r_opb;
    lc3b_fwd_sel  r_opsr;

    lc3b_hz_entry           w_id_entry;
    logic [c_MAX_REG_W-1:0] w_sr1;
    logic [c_MAX_REG_W-1:0] w_sr2;
    lc3b_fwd_sel            w_sel_a;
    lc3b_fwd_sel            w_sel_b;
    lc3b_fwd_sel            w_sel_s;
    logic                   w_lu_a;
    logic                   w_lu_b;
    logic                   w_lu_s;
    logic                   w_id_live;
    logic                   w_lu_hazard;
    logic                   w_mem_wait;
    logic                   w_adv;
    logic                   w_ex_bubble;
    logic                   w_kill_ex;
    logic                   w_unused;

    assign w_sr1 = c_MAX_REG_W'(bus.id_sr1);
    assign w_sr2 = c_MAX_REG_W'(bus.id_sr2);

    always_comb begin
        w_id_entry         = '0;
        w_id_entry.valid   = bus.id_valid;
        w_id_entry.dest    = c_MAX_REG_W'(bus.id_dest);
        w_id_entry.we      = bus.id_we;
        w_id_entry.is_load = bus.id_is_load;
    end

    fwd_compare u_cmp_opa (
        .src       (w_sr1),
        .use_src   (bus.id_uses_sr1),
        .ex_entry  (r_ex),
        .mem_entry (r_mem),
        .sel       (w_sel_a),
        .lu_hit    (w_lu_a)
    );

    fwd_compare u_cmp_opb (
        .src       (w_sr2),
        .use_src   (bus.id_uses_sr2),
        .ex_entry  (r_ex),
        .mem_entry (r_mem),
        .sel       (w_sel_b),
        .lu_hit    (w_lu_b)
    );

    fwd_compare u_cmp_opsr (
        .src       (w_sr2),
        .use_src   (bus.id_uses_srstore),
        .ex_entry  (r_ex),
        .mem_entry (r_mem),
        .sel       (w_sel_s),
        .lu_hit    (w_lu_s)
    );

    assign w_id_live   = bus.id_valid && !bus.flush;
    assign w_lu_hazard = w_id_live && (w_lu_a || w_lu_b || w_lu_s);
    assign w_mem_wait  = bus.mem_req && !bus.mem_resp;

    // Pipeline movement seen by the tracking registers on this edge.
    always_comb begin
        w_adv       = 1'b0;
        w_ex_bubble = 1'b1;
        w_kill_ex   = 1'b0;
        unique case (r_state)
            HZ_RUN: begin
                if (!w_mem_wait) begin
                    w_adv       = 1'b1;
                    w_ex_bubble = w_lu_hazard || !w_id_live;
                end
            end
            HZ_LU: begin
                if (!w_mem_wait) begin
                    w_adv       = 1'b1;
                    w_ex_bubble = !w_id_live || (r_cnt != 2'd0);
                end
            end
            HZ_MWAIT: begin
                // A flush held off during the wait lands on the resume edge.
                w_kill_ex = bus.mem_resp && bus.flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex   <= '0;
            r_mem  <= '0;
            r_wb   <= '0;
            r_opa  <= FWD_RF;
            r_opb  <= FWD_RF;
            r_opsr <= FWD_RF;
        end else if (w_adv) begin
            r_ex   <= w_ex_bubble ? lc3b_hz_entry'('0) : w_id_entry;
            r_mem  <= r_ex;
            r_wb   <= r_mem;
            r_opa  <= w_ex_bubble ? FWD_RF : w_sel_a;
            r_opb  <= w_ex_bubble ? FWD_RF : w_sel_b;
            r_opsr <= w_ex_bubble ? FWD_RF : w_sel_s;
        end else if (w_kill_ex) begin
            r_ex.valid <= 1'b0;
            r_opa      <= FWD_RF;
            r_opb      <= FWD_RF;
            r_opsr     <= FWD_RF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= HZ_RUN;
            r_resume <= HZ_RUN;
            r_cnt    <= 2'd0;
            r_stall  <= 1'b0;
            r_bubble <= 1'b0;
            r_freeze <= 1'b0;
        end else begin
            unique case (r_state)
                HZ_RUN: begin
                    if (w_mem_wait) begin
                        r_state  <= HZ_MWAIT;
                        r_resume <= HZ_RUN;
                        r_stall  <= 1'b1;
                        r_bubble <= 1'b0;
                        r_freeze <= 1'b1;
                    end else if (w_lu_hazard) begin
                        r_state  <= HZ_LU;
                        r_cnt    <= c_LU_INIT;
                        r_stall  <= 1'b1;
                        r_bubble <= 1'b1;
                        r_freeze <= 1'b0;
                    end else begin
                        r_stall  <= 1'b0;
                        r_bubble <= 1'b0;
                        r_freeze <= 1'b0;
                    end
                end
                HZ_LU: begin
                    if (w_mem_wait) begin
                        r_state  <= HZ_MWAIT;
                        r_resume <= HZ_LU;
                        r_stall  <= 1'b1;
                        r_bubble <= 1'b0;
                        r_freeze <= 1'b1;
                    end else if (bus.flush || (r_cnt == 2'd0)) begin
                        r_state  <= HZ_RUN;
                        r_cnt    <= 2'd0;
                        r_stall  <= 1'b0;
                        r_bubble <= 1'b0;
                        r_freeze <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt - 2'd1;
                        r_stall  <= 1'b1;
                        r_bubble <= 1'b1;
                    end
                end
                HZ_MWAIT: begin
                    if (bus.mem_resp) begin
                        r_freeze <= 1'b0;
                        if (bus.flush || (r_resume == HZ_RUN)) begin
                            r_state  <= HZ_RUN;
                            r_cnt    <= 2'd0;
                            r_stall  <= 1'b0;
                            r_bubble <= 1'b0;
                        end else begin
                            r_state  <= HZ_LU;
                            r_stall  <= 1'b1;
                            r_bubble <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= HZ_RUN;
                    r_stall  <= 1'b0;
                    r_bubble <= 1'b0;
                    r_freeze <= 1'b0;
                end
            endcase
        end
    end

    // WB is tracked for pipeline bookkeeping only; write-through covers it.
    assign w_unused = ^r_wb;

    assign bus.opAmux_sel  = r_opa;
    assign bus.opBmux_sel  = r_opb;
    assign bus.opSrmux_sel = r_opsr;
    assign bus.stall_if_id = r_stall;
    assign bus.bubble_ex   = r_bubble;
    assign bus.freeze      = r_freeze;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fwd_hazard_ctrl: directed instruction sequences with hand-worked selects|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fwd_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    fwd_hazard_ctrl_if #(.REG_W(3)) bus();

    fwd_hazard_ctrl #(.REG_W(3), .LU_STALL(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] s, input logic stall, input logic bub,
                             input logic frz);
        check({tag, ".opA"},    8'(bus.opAmux_sel),  8'(a));
        check({tag, ".opB"},    8'(bus.opBmux_sel),  8'(b));
        check({tag, ".opSr"},   8'(bus.opSrmux_sel), 8'(s));
        check({tag, ".stall"},  8'(bus.stall_if_id), 8'(stall));
        check({tag, ".bubble"}, 8'(bus.bubble_ex),   8'(bub));
        check({tag, ".freeze"}, 8'(bus.freeze),      8'(frz));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [2:0] sr1, input logic [2:0] sr2,
                         input logic u1, input logic u2, input logic ust,
                         input logic [2:0] dest, input logic we, input logic ld);
        bus.id_valid        = v;
        bus.id_sr1          = sr1;
        bus.id_sr2          = sr2;
        bus.id_uses_sr1     = u1;
        bus.id_uses_sr2     = u2;
        bus.id_uses_srstore = ust;
        bus.id_dest         = dest;
        bus.id_we           = we;
        bus.id_is_load      = ld;
    endtask

    initial begin
        bus.flush    = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_resp = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        check_out("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // ADD R1,R2,R3 ; ADD R4,R1,R1
        issue(1, 2, 3, 1, 1, 0, 1, 1, 0); tick();
        check_out("add1", 0, 0, 0, 0, 0, 0);
        issue(1, 1, 1, 1, 1, 0, 4, 1, 0); tick();
        check_out("raw_ex", 1, 1, 0, 0, 0, 0);

        // ADD R1 ; NOP ; AND R5,R1,#3 (sr2 field aliases R1 but is unused)
        issue(1, 2, 3, 1, 1, 0, 1, 1, 0); tick();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        check_out("nop", 0, 0, 0, 0, 0, 0);
        issue(1, 1, 1, 1, 0, 0, 5, 1, 0); tick();
        check_out("raw_mem", 2, 0, 0, 0, 0, 0);

        // ADD R1,R2,R3 ; ADD R1,R1,R5 ; ADD R6,R1,R1 (EX beats MEM)
        issue(1, 2, 3, 1, 1, 0, 1, 1, 0); tick();
        issue(1, 1, 5, 1, 1, 0, 1, 1, 0); tick();
        check_out("ex_and_mem", 1, 2, 0, 0, 0, 0);
        issue(1, 1, 1, 1, 1, 0, 6, 1, 0); tick();
        check_out("ex_over_mem", 1, 1, 0, 0, 0, 0);

        // LDR R3,R6,#0 ; ADD R4,R3,R2 -> one bubble, then forward from WB path
        issue(1, 6, 0, 1, 0, 0, 3, 1, 1); tick();
        check_out("ldr", 1, 0, 0, 0, 0, 0);
        issue(1, 3, 2, 1, 1, 0, 4, 1, 0); tick();
        check_out("lu_stall", 0, 0, 0, 1, 1, 0);
        tick();
        check_out("lu_done", 2, 0, 0, 0, 0, 0);

        // ADD R2,R1,R1 ; STR R2,R6,#1
        issue(1, 1, 1, 1, 1, 0, 2, 1, 0); tick();
        check_out("add_r2", 0, 0, 0, 0, 0, 0);
        issue(1, 6, 2, 1, 0, 1, 0, 0, 0); tick();
        check_out("str", 0, 0, 1, 0, 0, 0);

        // Memory wait for 3 cycles with ADD R7,R2,R2 waiting in ID
        issue(1, 2, 2, 1, 1, 0, 7, 1, 0);
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("mwait%0d", i), 0, 0, 1, 1, 0, 1);
        end
        bus.mem_resp = 1'b1; tick();
        check_out("resume", 0, 0, 1, 0, 0, 0);
        bus.mem_req = 1'b0; bus.mem_resp = 1'b0; tick();
        check_out("post_wait", 2, 2, 0, 0, 0, 0);

        // Flush in RUN kills the entering instruction and its forwarding
        issue(1, 7, 7, 1, 1, 0, 3, 1, 0);
        bus.flush = 1'b1; tick();
        check_out("flush_run", 0, 0, 0, 0, 0, 0);
        bus.flush = 1'b0;
        issue(1, 3, 7, 1, 1, 0, 1, 1, 0); tick();
        check_out("after_flush", 0, 2, 0, 0, 0, 0);

        // Asynchronous reset taken while in LU
        issue(1, 6, 0, 1, 0, 0, 3, 1, 1); tick();
        issue(1, 3, 3, 1, 1, 0, 4, 1, 0); tick();
        check_out("lu_again", 0, 0, 0, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        tick();
        check_out("post_rst", 0, 0, 0, 0, 0, 0);

        // Flush during LU aborts the stall
        issue(1, 6, 0, 1, 0, 0, 3, 1, 1); tick();
        issue(1, 3, 3, 1, 1, 0, 4, 1, 0); tick();
        check_out("lu_pre_flush", 0, 0, 0, 1, 1, 0);
        bus.flush = 1'b1; tick();
        check_out("lu_flush", 0, 0, 0, 0, 0, 0);
        bus.flush = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
